// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared types and constants for the data-memory responder:
//            FSM state encoding, data/address widths, wait counter width.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;
    // Wide enough for WAIT_CYCLES up to 15.
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_if
// Purpose  : Data-side request/response bus between an initiator and the
//            memory responder.
// Signals  : req, we, a, wd   (initiator -> responder)
//            rdata, ack, err, busy (responder -> initiator)
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [WORD_W-1:0] wd;
    logic [WORD_W-1:0] rdata;
    logic              ack;
    logic              err;
    logic              busy;

    modport master (output req, we, a, wd, input rdata, ack, err, busy);
    modport slave  (input req, we, a, wd, output rdata, ack, err, busy);

endinterface : dmem_responder_if
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Purpose  : Single-port DEPTH x 32 storage, synchronous write, registered
//            read. The read register only loads on a read access, so it holds
//            the last read value across writes and idle cycles.
// Ports    : clk, reset   - clock, async active-high reset (read reg only)
//            i_en, i_we   - access enable, write select
//            i_addr       - word index
//            i_wdata      - write data
//            o_rdata      - registered read data
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  wire                     clk,
    input  wire                     reset,
    input  wire                     i_en,
    input  wire                     i_we,
    input  wire [$clog2(DEPTH)-1:0] i_addr,
    input  wire [WORD_W-1:0]        i_wdata,
    output logic [WORD_W-1:0]       o_rdata
);

    // Storage is deliberately not reset.
    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_en && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Wait-state data-memory responder. Accepts one request at a time
//            in IDLE, inserts WAIT_CYCLES wait states, accesses the array and
//            returns a one-cycle ack. Misaligned or out-of-range addresses
//            are answered immediately with err=1 and touch nothing.
// Ports    : clk   - clock
//            reset - asynchronous active-high reset
//            bus   - dmem_responder_if.slave (req/we/a/wd in,
//                    rdata/ack/err/busy out, all outputs registered)
// Options  : DMEM_WRITE_POST_EN - valid writes are acked at error latency and
//            committed from a one-entry post buffer WAIT_CYCLES+1 cycles
//            later; new requests stall while the entry is pending.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  wire            clk,
    input  wire            reset,
    dmem_responder_if.slave bus
);

    localparam int               c_idx_w     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_wait_init = CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_we;
    logic [c_idx_w-1:0] r_idx;
    logic [WORD_W-1:0]  r_wd;
    logic               r_ack;
    logic               r_err;
    logic               r_busy;
    logic               w_capture;
    logic               w_err_next;
    logic               w_bad;
    logic               w_stall;
    logic               w_mem_en;
    logic               w_mem_we;
    logic               w_busy_next;
    logic [WORD_W-1:0]  w_rdata;

    // Index bits above the array range, or any byte offset, make the request illegal.
    assign w_bad = (|bus.a[1:0]) | (|bus.a[ADDR_W-1:c_idx_w+2]);

`ifdef DMEM_WRITE_POST_EN
    localparam logic [CNT_W-1:0] c_post_init = CNT_W'(WAIT_CYCLES);

    logic r_pend;
    logic w_pend_next;

    // The posted entry reuses the captured idx/wd registers: nothing new is
    // accepted while it is pending, so they cannot be overwritten.
    assign w_stall = r_pend;
`else
    assign w_stall = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        w_err_next   = 1'b0;
        w_mem_en     = 1'b0;
        w_mem_we     = r_we;
`ifdef DMEM_WRITE_POST_EN
        w_pend_next  = r_pend;
`endif
        case (r_state)
            IDLE: begin
                if (bus.req && !w_stall) begin
                    w_capture = 1'b1;
                    if (w_bad) begin
                        w_state_next = RESP;
                        w_err_next   = 1'b1;
`ifdef DMEM_WRITE_POST_EN
                    end else if (bus.we) begin
                        w_state_next = RESP;
                        w_pend_next  = 1'b1;
                        w_cnt_next   = c_post_init;
`endif
                    end else if (WAIT_CYCLES == 0) begin
                        w_state_next = ACCESS;
                    end else begin
                        w_state_next = WAIT;
                        w_cnt_next   = c_wait_init;
                    end
                end
            end
            WAIT: begin
                // Counter stops at zero on the exit edge; it never wraps.
                if (r_cnt == '0) begin
                    w_state_next = ACCESS;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ACCESS: begin
                w_mem_en     = 1'b1;
                w_state_next = RESP;
            end
            RESP: begin
                // Leave unconditionally; a still-high req is seen again in IDLE.
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
`ifdef DMEM_WRITE_POST_EN
        // Posted writes never pass through WAIT/ACCESS, so the counter and
        // the array port are free for the commit countdown.
        if (r_pend) begin
            if (r_cnt == '0) begin
                w_mem_en    = 1'b1;
                w_mem_we    = 1'b1;
                w_pend_next = 1'b0;
            end else begin
                w_cnt_next = r_cnt - CNT_W'(1);
            end
        end
        w_busy_next = (w_state_next != IDLE) | w_pend_next;
`else
        w_busy_next = (w_state_next != IDLE);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wd    <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            // Outputs are registered from the next state so ack/err line up
            // with the RESP cycle itself.
            r_ack   <= (w_state_next == RESP);
            r_err   <= w_err_next;
            r_busy  <= w_busy_next;
            if (w_capture) begin
                r_we  <= bus.we;
                r_idx <= bus.a[c_idx_w+1:2];
                r_wd  <= bus.wd;
            end
        end
    end

`ifdef DMEM_WRITE_POST_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= w_pend_next;
        end
    end
`endif

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_mem_en),
        .i_we    (w_mem_we),
        .i_addr  (r_idx),
        .i_wdata (r_wd),
        .o_rdata (w_rdata)
    );

    assign bus.rdata = w_rdata;
    assign bus.ack   = r_ack;
    assign bus.err   = r_err;
    assign bus.busy  = r_busy;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Directed self-checking bench. u_dut0 uses DEPTH=64,
//            WAIT_CYCLES=2; u_dut1 uses WAIT_CYCLES=0 for back-to-back
//            throughput. Edge counts below include the capture edge, so a
//            normal access acks after WAIT_CYCLES+2 edges, an error after 1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

`ifdef DMEM_WRITE_POST_EN
    localparam int c_wr_edges = 1;
`else
    localparam int c_wr_edges = 4;
`endif
    localparam int c_rd_edges  = 4;
    localparam int c_err_edges = 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    dmem_responder_if bus0();
    dmem_responder_if bus1();

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd);
        bus0.req = 1'b1;
        bus0.we  = we;
        bus0.a   = a;
        bus0.wd  = wd;
    endtask

    // Counts rising edges until ack is seen; bounded so a dead DUT cannot hang.
    task automatic wait_ack(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (bus0.ack !== 1'b1 && edges < 60);
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (bus0.busy !== 1'b0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("settle_busy", {31'd0, bus0.busy}, 32'd0);
    endtask

    task automatic op(input string tag, input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input int exp_edges,
                      input logic exp_err, input logic [31:0] exp_rdata);
        int edges;
        drive(we, a, wd);
        wait_ack(edges);
        bus0.req = 1'b0;
        chk({tag, "_edges"}, edges, exp_edges);
        chk({tag, "_ack"}, {31'd0, bus0.ack}, 32'd1);
        chk({tag, "_err"}, {31'd0, bus0.err}, {31'd0, exp_err});
        chk({tag, "_rdata"}, bus0.rdata, exp_rdata);
        @(posedge clk);
        #1;
        chk({tag, "_ack_drop"}, {31'd0, bus0.ack}, 32'd0);
        chk({tag, "_err_drop"}, {31'd0, bus0.err}, 32'd0);
        settle();
    endtask

    initial begin
        int edges;
        int n_ack;
        int first_ack;
        logic prev_ack;
        logic dbl_ack;

        bus0.req = 1'b0; bus0.we = 1'b0; bus0.a = '0; bus0.wd = '0;
        bus1.req = 1'b0; bus1.we = 1'b0; bus1.a = '0; bus1.wd = '0;

        // Asynchronous reset takes effect without a clock edge.
        #2 reset = 1'b1;
        #1;
        chk("rst_ack",   {31'd0, bus0.ack},  32'd0);
        chk("rst_err",   {31'd0, bus0.err},  32'd0);
        chk("rst_busy",  {31'd0, bus0.busy}, 32'd0);
        chk("rst_rdata", bus0.rdata,         32'd0);
        chk("rst_busy1", {31'd0, bus1.busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        op("wr20",  1'b1, 32'h20,  32'hCAFEF00D, c_wr_edges,  1'b0, 32'h0);
        op("wr00",  1'b1, 32'h0,   32'h55AA55AA, c_wr_edges,  1'b0, 32'h0);
        op("wr10",  1'b1, 32'h10,  32'hDEADBEEF, c_wr_edges,  1'b0, 32'h0);
        op("rd10",  1'b0, 32'h10,  32'h0,        c_rd_edges,  1'b0, 32'hDEADBEEF);
        op("rd06",  1'b0, 32'h6,   32'h0,        c_err_edges, 1'b1, 32'hDEADBEEF);
        op("rd100", 1'b0, 32'h100, 32'h0,        c_err_edges, 1'b1, 32'hDEADBEEF);
        op("wrFC",  1'b1, 32'hFC,  32'h0BADC0DE, c_wr_edges,  1'b0, 32'hDEADBEEF);
        op("rdFC",  1'b0, 32'hFC,  32'h0,        c_rd_edges,  1'b0, 32'h0BADC0DE);
        // 0x100 and 0x2 both alias index 0 if the error path leaked a write.
        op("wr100", 1'b1, 32'h100, 32'h11111111, c_err_edges, 1'b1, 32'h0BADC0DE);
        op("wr02",  1'b1, 32'h2,   32'h22222222, c_err_edges, 1'b1, 32'h0BADC0DE);
        op("rd00",  1'b0, 32'h0,   32'h0,        c_rd_edges,  1'b0, 32'h55AA55AA);
        op("rd10b", 1'b0, 32'h10,  32'h0,        c_rd_edges,  1'b0, 32'hDEADBEEF);

        // req still high on the edge leaving RESP must not restart.
        drive(1'b0, 32'h10, 32'h0);
        wait_ack(edges);
        chk("hold_edges", edges, c_rd_edges);
        @(posedge clk);
        #1;
        chk("hold_ack",  {31'd0, bus0.ack},  32'd0);
        chk("hold_busy", {31'd0, bus0.busy}, 32'd0);
        bus0.req = 1'b0;

        // Reset in the middle of a write.
        drive(1'b1, 32'h20, 32'h12345678);
        @(posedge clk);
        #1;
        bus0.req = 1'b0;
        chk("mid_busy", {31'd0, bus0.busy}, 32'd1);
        chk("mid_ack",  {31'd0, bus0.ack},  32'd0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_ack",   {31'd0, bus0.ack},  32'd0);
        chk("midrst_busy",  {31'd0, bus0.busy}, 32'd0);
        chk("midrst_rdata", bus0.rdata,         32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        op("rd20", 1'b0, 32'h20, 32'h0, c_rd_edges, 1'b0, 32'hCAFEF00D);

        // WAIT_CYCLES=0 with req held: IDLE, ACCESS, RESP repeating.
        bus1.req = 1'b1;
        bus1.we  = 1'b0;
        bus1.a   = 32'h4;
        n_ack     = 0;
        first_ack = -1;
        prev_ack  = 1'b0;
        dbl_ack   = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (bus1.ack === 1'b1) begin
                n_ack++;
                if (first_ack < 0) first_ack = i;
                if (prev_ack) dbl_ack = 1'b1;
            end
            prev_ack = (bus1.ack === 1'b1);
        end
        bus1.req = 1'b0;
        chk("b2b_count", n_ack,            32'd10);
        chk("b2b_first", first_ack,        32'd2);
        chk("b2b_dbl",   {31'd0, dbl_ack}, 32'd0);

`ifdef DMEM_WRITE_POST_EN
        // Posted write then immediate read: read stalls until commit.
        drive(1'b1, 32'h8, 32'hA5A5A5A5);
        wait_ack(edges);
        chk("post_wr_edges", edges, 32'd1);
        drive(1'b0, 32'h8, 32'h0);
        @(posedge clk);
        #1;
        chk("post_stall_busy", {31'd0, bus0.busy}, 32'd1);
        chk("post_stall_ack",  {31'd0, bus0.ack},  32'd0);
        wait_ack(edges);
        bus0.req = 1'b0;
        chk("post_rd_edges", edges, 32'd6);
        chk("post_rd_err",   {31'd0, bus0.err}, 32'd0);
        chk("post_rd_rdata", bus0.rdata, 32'hA5A5A5A5);
        settle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_dmem_responder
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit words in the data array (power of two, 4..1024).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted before each array access (0..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port req, input, 1, the data-side initiator holds it high until ack.
REQ-006 SHALL have port we, input, 1, 1 = write, 0 = read; qualified by req.
REQ-007 SHALL have port a, input, 32, byte address.
REQ-008 SHALL have port wd, input, 32, write data.
REQ-009 SHALL have port rdata, output, 32, read data, valid when ack=1 and err=0 for a read.
REQ-010 SHALL have port ack, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port err, output, 1, error flag, meaningful only with ack.
REQ-012 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, ACCESS and RESP; all outputs SHALL be registered.
REQ-014 IDLE with req=1 at edge k SHALL capture we, a and wd; idx = a[log2(DEPTH)+1:2].
REQ-015 A request with a[1:0]!=0 or a[31:2]>=DEPTH SHALL go IDLE->RESP with err=1; the array is untouched and rdata is unchanged.
REQ-016 A valid request SHALL go IDLE->WAIT with counter=WAIT_CYCLES-1, or straight to ACCESS when WAIT_CYCLES=0.
REQ-017 WAIT SHALL decrement the counter each cycle and go to ACCESS on the edge where counter=0; the counter never wraps.
REQ-018 ACCESS SHALL write mem[idx]<=wd, or load rdata<=mem[idx], then go to RESP.
REQ-019 RESP SHALL drive ack=1 for exactly one cycle, then return to IDLE.
REQ-020 Latency: ack SHALL be high in the cycle after edge k+WAIT_CYCLES+1; error acks SHALL appear in the cycle after edge k.
REQ-021 req SHALL be ignored outside IDLE; req still high on the edge leaving RESP SHALL NOT start a new transaction.
REQ-022 rdata SHALL hold its last read value across writes and errors.
REQ-023 err SHALL be 0 whenever ack=0.

Reset
REQ-024 reset SHALL force state=IDLE, counter=0, ack=0, err=0, busy=0 and rdata=0 immediately, including in the middle of a transaction.
REQ-025 A write interrupted by reset before ACCESS SHALL NOT modify the array; array contents SHALL NOT be reset.
REQ-026 reset SHALL dominate a simultaneous req.

Configuration
REQ-027 Macro DMEM_WRITE_POST_EN SHALL be the only compile option.
REQ-028 With DMEM_WRITE_POST_EN defined, a valid write SHALL go IDLE->RESP (ack at the same latency as an error), be held in a one-entry post buffer, and commit to the array WAIT_CYCLES+1 cycles later.
REQ-029 With DMEM_WRITE_POST_EN defined, a request arriving while the buffer is pending SHALL remain unaccepted (busy=1) until the commit.
REQ-030 With DMEM_WRITE_POST_EN defined, reset SHALL discard any pending buffer entry.
REQ-031 Without DMEM_WRITE_POST_EN, writes SHALL follow REQ-016..REQ-020 and no buffer logic SHALL exist.

Structure
REQ-032 Package dmem_pkg SHALL hold the state encoding constants (IDLE, WAIT, ACCESS, RESP), WORD_W=32 and the counter width.
REQ-033 Sub-module dmem_array SHALL be a single-port, DEPTH x 32 array with synchronous write and registered read, instantiated once.

Verification
REQ-034 Reset, write a=0x10, wd=0xDEADBEEF, then read a=0x10 -> ack at latency 3 cycles each (WAIT_CYCLES=2), rdata=0xDEADBEEF, err=0.
REQ-035 Read a=0x0000_0006 -> ack in the next cycle, err=1, rdata unchanged, array unchanged.
REQ-036 Read a=0x100 with DEPTH=64 -> err=1; read a=0xFC -> err=0.
REQ-037 Assert reset during WAIT of a write wd=0x12345678 to a=0x20 -> ack=0, rdata=0, later read of a=0x20 returns the old value.
REQ-038 With WAIT_CYCLES=0, back-to-back requests with req held high -> exactly one ack per 3 cycles, never two consecutive ack cycles.
REQ-039 With DMEM_WRITE_POST_EN, write 0xA5A5A5A5 to 0x8 then immediately read 0x8 -> write ack after 1 cycle, read stalled until commit, rdata=0xA5A5A5A5.
